// File: rtl/countdown_arbiter.sv
// countdown_arbiter: one shared down-counter handed out round-robin
// to N_REQ requesters, with done/abort pulses back to the owner.
module countdown_arbiter #(
   parameter int N_REQ = 4,
   parameter int CNT_W = 4
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*CNT_W-1:0] req_count,
   input  logic                   tick,
   output logic [N_REQ-1:0]       grant,
   output logic [N_REQ-1:0]       done,
   output logic [N_REQ-1:0]       abort,
   output logic                   busy,
   output logic [CNT_W-1:0]       value,
   output logic                   zero
);
   localparam int PTR_W = $clog2(N_REQ);
   localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      COUNT,
      DONE,
      ABORT
   } state_t;

   state_t           state;
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] owner;
   logic [PTR_W-1:0] win;
   logic [PTR_W-1:0] idx;
   logic [CNT_W-1:0] load_val;
   logic             own_req;

   assign zero     = ~|value;
   assign own_req  = req[owner];
   assign load_val = req_count[int'(owner)*CNT_W +: CNT_W];

   // Scan from farthest to nearest so the nearest set bit after rr_ptr wins.
   always_comb begin
      win = '0;
      idx = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = PTR_W'((int'(rr_ptr) + k) % N_REQ);
         if (req[idx]) win = idx;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         rr_ptr <= PTR_W'(N_REQ - 1);
         owner  <= '0;
         grant  <= '0;
         done   <= '0;
         abort  <= '0;
         busy   <= 1'b0;
         value  <= '0;
      end else begin
         done  <= '0;
         abort <= '0;
         unique case (state)
            IDLE: begin
               if (|req) begin
                  owner <= win;
                  grant <= ONE << win;
                  busy  <= 1'b1;
                  state <= LOAD;
               end
            end
            LOAD: begin
               if (!own_req) begin
                  abort <= grant;
                  state <= ABORT;
               end else begin
                  value <= load_val;
                  state <= COUNT;
               end
            end
            COUNT: begin
               // A dropped request outranks expiry in the same cycle.
               if (!own_req) begin
                  abort <= grant;
                  state <= ABORT;
               end else if (zero) begin
                  done  <= grant;
                  state <= DONE;
               end else if (tick) begin
                  value <= value - 1'b1;
               end
            end
            DONE, ABORT: begin
               rr_ptr <= owner;
               grant  <= '0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_countdown_arbiter.sv
// Bench for countdown_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_countdown_arbiter;
   localparam int N  = 4;
   localparam int W  = 4;
   localparam int CW = N * W;
   localparam int VW = 3 * N + W + 2;

   logic          clock = 1'b0;
   logic          reset_n = 1'b1;
   logic [N-1:0]  req = '0;
   logic [CW-1:0] req_count = '0;
   logic          tick = 1'b0;
   logic [N-1:0]  grant, done, abort;
   logic          busy, zero;
   logic [W-1:0]  value;

   int checks = 0;
   int failures = 0;

   // Reference: phase 0 idle, 1 load, 2 count, 3 done, 4 abort.
   int m_phase, m_owner, m_ptr, m_val;

   countdown_arbiter #(.N_REQ(N), .CNT_W(W)) dut (
      .clock(clock), .reset_n(reset_n), .req(req),
      .req_count(req_count), .tick(tick), .grant(grant),
      .done(done), .abort(abort), .busy(busy),
      .value(value), .zero(zero)
   );

   always #5 clock = ~clock;

   function automatic logic [VW-1:0] exp_vec();
      logic [N-1:0] one, g, d, a;
      one = 1;
      g = (m_phase != 0) ? one << m_owner : '0;
      d = (m_phase == 3) ? g : '0;
      a = (m_phase == 4) ? g : '0;
      return {g, d, a, m_phase != 0, W'(m_val), m_val == 0};
   endfunction

   function automatic logic [VW-1:0] obs_vec();
      return {grant, done, abort, busy, value, zero};
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_owner = 0;
      m_ptr   = N - 1;
      m_val   = 0;
   endtask

   // Advance one clock; model consumes the inputs present at the edge.
   task automatic step();
      int o;
      @(posedge clock);
      o = m_owner;
      case (m_phase)
         0: if (req != 0) begin
            for (int k = N; k >= 1; k--)
               if (req[(m_ptr + k) % N]) o = (m_ptr + k) % N;
            m_owner = o;
            m_phase = 1;
         end
         1: if (!req[m_owner]) m_phase = 4;
            else begin
               m_val   = int'(req_count[m_owner*W +: W]);
               m_phase = 2;
            end
         2: if (!req[m_owner]) m_phase = 4;
            else if (m_val == 0) m_phase = 3;
            else if (tick) m_val = m_val - 1;
         default: begin
            m_ptr   = m_owner;
            m_phase = 0;
         end
      endcase
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clock);
      reset_n = 1'b0;
      req = '0;
      tick = 1'b0;
      #2;
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (obs_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL reset_state got=%h want=%h", obs_vec(), exp_vec());
      end
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_single();
      int vt[8] = '{0, 0, 3, 2, 1, 0, 0, 0};
      req = 4'b0001;
      req_count = {4'd9, 4'd9, 4'd9, 4'd3};
      tick = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         step();
         if (e == 6) req = '0;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL single e=%0d got=%h want=%h", e, obs_vec(), exp_vec());
         end
         checks++;
         if (value !== W'(vt[e]) || done !== ((e == 6) ? 4'b0001 : 4'b0000)
             || busy !== (e != 7) || grant !== ((e <= 6) ? 4'b0001 : 4'b0000)) begin
            failures++;
            $display("FAIL single_seq e=%0d value=%0d done=%b busy=%b grant=%b",
                     e, value, done, busy, grant);
         end
      end
   endtask

   task automatic test_zero_count();
      req = 4'b0010;
      req_count = {4'd7, 4'd7, 4'd0, 4'd7};
      tick = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         step();
         if (e == 3) req = '0;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL zero_cnt e=%0d got=%h want=%h", e, obs_vec(), exp_vec());
         end
         checks++;
         if (value !== '0 || done !== ((e == 3) ? 4'b0010 : 4'b0000)) begin
            failures++;
            $display("FAIL zero_cnt_seq e=%0d value=%0d done=%b", e, value, done);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] order[$];
      logic [N-1:0] want[4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
      apply_reset();
      req_count = {4'd2, 4'd2, 4'd2, 4'd2};
      tick = 1'b1;
      for (int round = 0; round < 2; round++) begin
         req = 4'b0101;
         for (int c = 0; c < 40 && !(req == 0 && m_phase == 0); c++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
               failures++;
               $display("FAIL rr c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (done != 0) order.push_back(done);
            if (m_phase == 3) req[m_owner] = 1'b0;
         end
      end
      checks++;
      if (order.size() != 4) begin
         failures++;
         $display("FAIL rr_count got=%0d want=4", order.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (order[i] !== want[i]) begin
               failures++;
               $display("FAIL rr_order i=%0d got=%b want=%b", i, order[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_tick_gating();
      req = 4'b0001;
      req_count = {4'd5, 4'd5, 4'd5, 4'd2};
      for (int e = 1; e <= 8; e++) begin
         tick = (e % 2 == 0);
         step();
         if (e == 7) req = '0;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL tick e=%0d got=%h want=%h", e, obs_vec(), exp_vec());
         end
         checks++;
         if (done !== ((e == 7) ? 4'b0001 : 4'b0000)) begin
            failures++;
            $display("FAIL tick_done e=%0d got=%b", e, done);
         end
      end
   endtask

   task automatic test_abort();
      apply_reset();
      req = 4'b0011;
      req_count = {4'd3, 4'd3, 4'd1, 4'd5};
      tick = 1'b1;
      for (int e = 1; e <= 13; e++) begin
         step();
         if (e == 5) req[0] = 1'b0;
         if (m_phase == 3) req[m_owner] = 1'b0;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL abort e=%0d got=%h want=%h", e, obs_vec(), exp_vec());
         end
         if (e == 6 || e == 8) begin
            checks++;
            if ((e == 6 && (abort !== 4'b0001 || done !== '0 || value !== 4'd2))
                || (e == 8 && grant !== 4'b0010)) begin
               failures++;
               $display("FAIL abort_seq e=%0d abort=%b done=%b grant=%b value=%0d",
                        e, abort, done, grant, value);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      req = 4'b0100;
      req_count = {4'd0, 4'd5, 4'd0, 4'd0};
      tick = 1'b0;
      for (int e = 1; e <= 3; e++) step();
      checks++;
      if (value !== 4'd5 || obs_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL rmid_pre got=%h want=%h", obs_vec(), exp_vec());
      end
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (grant !== '0 || busy !== 1'b0 || value !== '0 || done !== '0) begin
         failures++;
         $display("FAIL rmid_now grant=%b busy=%b value=%0d done=%b",
                  grant, busy, value, done);
      end
      req = 4'b0101;
      @(negedge clock);
      reset_n = 1'b1;
      step();
      checks++;
      if (grant !== 4'b0001 || obs_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL rmid_prio got=%h want=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 600; c++) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(5) == 0) req[b] = ~req[b];
         req_count = CW'($urandom);
         tick = ($urandom_range(3) != 0);
         step();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL random c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_zero_count();
      test_round_robin();
      test_tick_gating();
      test_abort();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
